// File: rtl/frontend_cmd_intake_if.sv
// Frontend command bus: host-side command/write/read-return signals plus the
// backend scheduler handshake, bundled for the intake block.
interface frontend_cmd_intake_if #(
  parameter int CMD_W  = 32,
  parameter int DATA_W = 1024
);
  logic [CMD_W-1:0]  command;
  logic [DATA_W-1:0] write_data;
  logic              valid;
  logic              ba_cmd_pm;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;
  logic [CMD_W-1:0]  be_cmd;
  logic [DATA_W-1:0] be_wdata;
  logic              be_valid;
  logic              be_ready;
  logic [DATA_W-1:0] be_rdata;
  logic              be_rdata_valid;
  logic              proto_err;

  modport master (
    output command, write_data, valid, be_ready, be_rdata, be_rdata_valid,
    input  ba_cmd_pm, read_data, read_data_valid, be_cmd, be_wdata, be_valid,
           proto_err
  );

  modport slave (
    input  command, write_data, valid, be_ready, be_rdata, be_rdata_valid,
    output ba_cmd_pm, read_data, read_data_valid, be_cmd, be_wdata, be_valid,
           proto_err
  );
endinterface

// File: rtl/frontend_cmd_intake.sv
// Frontend command intake: command/write-data FIFOs, in-order issue with a
// bound on outstanding reads. Define FRONTEND_INTAKE_STAT_EN for accept counters.
module frontend_cmd_intake #(
  parameter int CMD_W     = 32,
  parameter int DATA_W    = 1024,
  parameter int CMD_DEPTH = 8,
  parameter int WD_DEPTH  = 8,
  parameter int MAX_OUTST = 16
) (
  input  logic                  clk,
  input  logic                  power_on_rst,
  frontend_cmd_intake_if.slave  bus
`ifdef FRONTEND_INTAKE_STAT_EN
  ,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_rd_cnt
`endif
);
  localparam int CA_W = $clog2(CMD_DEPTH);
  localparam int CC_W = $clog2(CMD_DEPTH + 1);
  localparam int WA_W = $clog2(WD_DEPTH);
  localparam int WC_W = $clog2(WD_DEPTH + 1);
  localparam int OC_W = $clog2(MAX_OUTST + 1);
  localparam logic [CC_W-1:0] CMD_FULL  = CC_W'(CMD_DEPTH);
  localparam logic [WC_W-1:0] WD_FULL   = WC_W'(WD_DEPTH);
  localparam logic [OC_W-1:0] OUTST_MAX = OC_W'(MAX_OUTST);
  // op_type occupies the top two bits of the packed command
  localparam logic [1:0] OP_WRITE = 2'd1;

  logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
  logic [DATA_W-1:0] wd_mem  [WD_DEPTH];
  logic [CA_W-1:0]   cmd_wp, cmd_rp;
  logic [WA_W-1:0]   wd_wp, wd_rp;
  logic [CC_W-1:0]   cmd_cnt;
  logic [WC_W-1:0]   wd_cnt;
  logic [OC_W-1:0]   outst_cnt;

  logic push_cmd, push_wd, pop_cmd, pop_wd, rd_issue, rvalid_ok, head_wr;
  logic [CMD_W-1:0] head;

  assign bus.ba_cmd_pm = !power_on_rst && (cmd_cnt < CMD_FULL) && (wd_cnt < WD_FULL);
  assign push_cmd = bus.valid && bus.ba_cmd_pm;
  assign push_wd  = push_cmd && (bus.command[CMD_W-1 -: 2] == OP_WRITE);

  assign head     = cmd_mem[cmd_rp];
  assign head_wr  = (head[CMD_W-1 -: 2] == OP_WRITE);
  assign bus.be_valid = (cmd_cnt != '0) &&
                        (head_wr ? (wd_cnt != '0) : (outst_cnt < OUTST_MAX));
  assign bus.be_cmd   = head;
  assign bus.be_wdata = head_wr ? wd_mem[wd_rp] : '0;

  assign pop_cmd  = bus.be_valid && bus.be_ready;
  assign pop_wd   = pop_cmd && head_wr;
  assign rd_issue = pop_cmd && !head_wr;
  // A return in the same cycle as a read issue from zero is legitimate
  assign rvalid_ok = bus.be_rdata_valid && ((outst_cnt != '0) || rd_issue);

  always_ff @(posedge clk) begin
    if (push_cmd) cmd_mem[cmd_wp] <= bus.command;
    if (push_wd)  wd_mem[wd_wp]   <= bus.write_data;
  end

  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      cmd_wp              <= '0;
      cmd_rp              <= '0;
      wd_wp               <= '0;
      wd_rp               <= '0;
      cmd_cnt             <= '0;
      wd_cnt              <= '0;
      outst_cnt           <= '0;
      bus.read_data       <= '0;
      bus.read_data_valid <= 1'b0;
      bus.proto_err       <= 1'b0;
    end else begin
      if (push_cmd) cmd_wp <= cmd_wp + 1'b1;
      if (pop_cmd)  cmd_rp <= cmd_rp + 1'b1;
      if (push_wd)  wd_wp  <= wd_wp + 1'b1;
      if (pop_wd)   wd_rp  <= wd_rp + 1'b1;
      cmd_cnt   <= cmd_cnt + CC_W'(push_cmd) - CC_W'(pop_cmd);
      wd_cnt    <= wd_cnt + WC_W'(push_wd) - WC_W'(pop_wd);
      outst_cnt <= outst_cnt + OC_W'(rd_issue) - OC_W'(rvalid_ok);
      bus.read_data_valid <= rvalid_ok;
      if (rvalid_ok) bus.read_data <= bus.be_rdata;
      if (bus.be_rdata_valid && !rvalid_ok) bus.proto_err <= 1'b1;
    end
  end

`ifdef FRONTEND_INTAKE_STAT_EN
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      if (push_wd && stat_wr_cnt != 32'hFFFF_FFFF) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (push_cmd && !push_wd && stat_rd_cnt != 32'hFFFF_FFFF)
        stat_rd_cnt <= stat_rd_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_frontend_cmd_intake.sv
// Directed bench for frontend_cmd_intake: streaming writes, FIFO full,
// outstanding-read limit, read return, protocol error and reset flush.
module tb_frontend_cmd_intake;
  localparam int CMD_W  = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] OP_R = 2'd0;
  localparam logic [1:0] OP_W = 2'd1;

  logic clk = 1'b0;
  logic power_on_rst;
  int   checks = 0;
  int   failures = 0;
  int   issued;

  frontend_cmd_intake_if #(.CMD_W(CMD_W), .DATA_W(DATA_W)) bus ();

`ifdef FRONTEND_INTAKE_STAT_EN
  logic [31:0] stat_wr_cnt, stat_rd_cnt;
`endif

  frontend_cmd_intake #(.CMD_W(CMD_W), .DATA_W(DATA_W), .CMD_DEPTH(8),
                        .WD_DEPTH(8), .MAX_OUTST(16)) dut (
    .clk          (clk),
    .power_on_rst (power_on_rst),
    .bus          (bus.slave)
`ifdef FRONTEND_INTAKE_STAT_EN
    ,
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [CMD_W-1:0] mk(input logic [1:0] op, input int row, input int col);
    logic [15:0] r;
    logic [11:0] c;
    r = 16'(row);
    c = 12'(col);
    return {op, 2'b00, r, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    power_on_rst = 1'b1;
    bus.command = '0; bus.write_data = '0; bus.valid = 1'b0;
    bus.be_ready = 1'b0; bus.be_rdata = '0; bus.be_rdata_valid = 1'b0;
    repeat (3) step();
    chk("rst_ba", 64'(bus.ba_cmd_pm), 64'd0);
    chk("rst_be_valid", 64'(bus.be_valid), 64'd0);
    chk("rst_rdv", 64'(bus.read_data_valid), 64'd0);
    chk("rst_rdata", 64'(bus.read_data), 64'd0);
    chk("rst_perr", 64'(bus.proto_err), 64'd0);
    power_on_rst = 1'b0;
    #1;
    chk("ba_after_rst", 64'(bus.ba_cmd_pm), 64'd1);

    // 16 streaming writes, each visible to the backend one cycle after accept
    bus.be_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.command = mk(OP_W, 0, k); bus.write_data = 32'(k); bus.valid = 1'b1;
      step();
      chk("t1_be_valid", 64'(bus.be_valid), 64'd1);
      chk("t1_be_cmd", 64'(bus.be_cmd), 64'(mk(OP_W, 0, k)));
      chk("t1_be_wdata", 64'(bus.be_wdata), 64'(k));
      chk("t1_ba", 64'(bus.ba_cmd_pm), 64'd1);
    end
    bus.valid = 1'b0;
    step();
    chk("t1_empty", 64'(bus.be_valid), 64'd0);

    // Fill both FIFOs with the backend stalled
    bus.be_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.command = mk(OP_W, 1, i); bus.write_data = 32'(100 + i); bus.valid = 1'b1;
      step();
      chk("t2_ba_fill", 64'(bus.ba_cmd_pm), (i < 7) ? 64'd1 : 64'd0);
    end
    bus.command = mk(OP_W, 1, 8); bus.write_data = 32'd108;
    step();
    chk("t2_ba_full", 64'(bus.ba_cmd_pm), 64'd0);
    chk("t2_head_hold", 64'(bus.be_cmd), 64'(mk(OP_W, 1, 0)));
    chk("t2_wd_hold", 64'(bus.be_wdata), 64'd100);
    bus.be_ready = 1'b1;
    step();
    chk("t2_ba_after_pop", 64'(bus.ba_cmd_pm), 64'd1);
    chk("t2_head1", 64'(bus.be_cmd), 64'(mk(OP_W, 1, 1)));
    step();
    bus.valid = 1'b0;
    for (int j = 2; j < 9; j++) begin
      chk("t2_drain_vld", 64'(bus.be_valid), 64'd1);
      chk("t2_drain_cmd", 64'(bus.be_cmd), 64'(mk(OP_W, 1, j)));
      chk("t2_drain_wd", 64'(bus.be_wdata), 64'(100 + j));
      step();
    end
    chk("t2_empty", 64'(bus.be_valid), 64'd0);
`ifdef FRONTEND_INTAKE_STAT_EN
    chk("stat_wr", 64'(stat_wr_cnt), 64'd25);
    chk("stat_rd", 64'(stat_rd_cnt), 64'd0);
`endif

    // 20 reads with no returns: only 16 may be outstanding
    issued = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) begin
        bus.command = mk(OP_R, 2, i); bus.valid = 1'b1;
      end else bus.valid = 1'b0;
      step();
      if (bus.be_valid) begin
        chk("t3_order", 64'(bus.be_cmd), 64'(mk(OP_R, 2, issued)));
        chk("t3_rd_wdata", 64'(bus.be_wdata), 64'd0);
        issued++;
      end
    end
    bus.valid = 1'b0;
    chk("t3_issued", 64'(issued), 64'd16);
    chk("t3_blocked", 64'(bus.be_valid), 64'd0);
    chk("t3_head", 64'(bus.be_cmd), 64'(mk(OP_R, 2, 16)));
    bus.be_rdata = 32'hA5; bus.be_rdata_valid = 1'b1;
    step();
    bus.be_rdata_valid = 1'b0;
    chk("t3_17th_vld", 64'(bus.be_valid), 64'd1);
    chk("t3_ret_rdv", 64'(bus.read_data_valid), 64'd1);
    chk("t3_ret_rdata", 64'(bus.read_data), 64'hA5);
    step();
    chk("t3_blocked2", 64'(bus.be_valid), 64'd0);
    chk("t3_rdv_pulse", 64'(bus.read_data_valid), 64'd0);

    // Return 16 reads back-to-back
    bus.be_ready = 1'b0;
    for (int d = 0; d < 16; d++) begin
      bus.be_rdata = 32'(d); bus.be_rdata_valid = 1'b1;
      step();
      chk("t4_rdv", 64'(bus.read_data_valid), 64'd1);
      chk("t4_rdata", 64'(bus.read_data), 64'(d));
    end
    bus.be_rdata_valid = 1'b0;
    step();
    chk("t4_rdv_off", 64'(bus.read_data_valid), 64'd0);
    chk("t4_rdata_hold", 64'(bus.read_data), 64'd15);

    // Spurious return with nothing outstanding
    bus.be_rdata = 32'h55; bus.be_rdata_valid = 1'b1;
    step();
    bus.be_rdata_valid = 1'b0;
    chk("t5_rdv", 64'(bus.read_data_valid), 64'd0);
    chk("t5_perr", 64'(bus.proto_err), 64'd1);
    chk("t5_rdata", 64'(bus.read_data), 64'd15);
    repeat (2) step();
    chk("t5_perr_sticky", 64'(bus.proto_err), 64'd1);

    // Reset with three reads still queued
    chk("t6_queued", 64'(bus.be_valid), 64'd1);
    power_on_rst = 1'b1;
    step();
    chk("t6_ba", 64'(bus.ba_cmd_pm), 64'd0);
    chk("t6_be_valid", 64'(bus.be_valid), 64'd0);
    chk("t6_perr", 64'(bus.proto_err), 64'd0);
    chk("t6_rdata", 64'(bus.read_data), 64'd0);
    power_on_rst = 1'b0;
    bus.be_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_reissue", 64'(bus.be_valid), 64'd0);
      chk("t6_ba_up", 64'(bus.ba_cmd_pm), 64'd1);
    end

    // Read issue and return in the same cycle from zero outstanding
    bus.command = mk(OP_R, 3, 5); bus.valid = 1'b1;
    #1;
    chk("t7_no_fallthru", 64'(bus.be_valid), 64'd0);
    step();
    bus.valid = 1'b0;
    chk("t7_vld", 64'(bus.be_valid), 64'd1);
    bus.be_rdata = 32'h77; bus.be_rdata_valid = 1'b1;
    step();
    bus.be_rdata_valid = 1'b0;
    chk("t7_rdv", 64'(bus.read_data_valid), 64'd1);
    chk("t7_rdata", 64'(bus.read_data), 64'h77);
    chk("t7_perr", 64'(bus.proto_err), 64'd0);
    chk("t7_empty", 64'(bus.be_valid), 64'd0);
    bus.be_rdata = 32'h88; bus.be_rdata_valid = 1'b1;
    step();
    bus.be_rdata_valid = 1'b0;
    chk("t7_drop_rdv", 64'(bus.read_data_valid), 64'd0);
    chk("t7_drop_perr", 64'(bus.proto_err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
